prm_chk_reader: RTL

Readout engine for the edge-check accumulator. On a start pulse it walks all 64 32-bit words of the 2048-bit accumulated edge result by driving the accumulator's `sel1`/`sel2` word-select inputs. It samples the returned `result_imp` word and streams each word out on a valid/ready interface, tagged with its word index. It sits between the accumulator and the host-side capture logic, replacing manual host stepping of the selects.

---
 rtl/prm_chk_pkg.sv | 42 ++++
 rtl/prm_chk_reader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/prm_chk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prm_chk_pkg                                                        |
// | Shared types and constants for the edge-check accumulator readout: |
// | FSM state encoding, result geometry and the word-index to select   |
// | mapping used by the reader and by the accumulator host driver.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package prm_chk_pkg;

   localparam int NUM_WORDS = 64;
   localparam int WORD_W    = 32;
   localparam int IDX_W     = 6;
   localparam int SEL1_W    = 2;
   localparam int SEL2_W    = 8;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEL  = 3'd1,
      CAP  = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef struct packed {
      logic [SEL1_W-1:0] sel1;
      logic [SEL2_W-1:0] sel2;
   } sel_t;

   // Word index -> accumulator selects: upper two bits pick the 512-bit
   // block, lower four bits pick the word inside it.
   function automatic sel_t idx_to_sel(input logic [IDX_W-1:0] idx);
      sel_t s;
      s.sel1 = idx[5:4];
      s.sel2 = {4'b0000, idx[3:0]};
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prm_chk_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prm_chk_reader                                                     |
// | Walks all 64 words of the accumulated edge result by driving the   |
// | accumulator selects, captures each returned word and streams it    |
// | out on a valid/ready port tagged with its word index.              |
// | Optional build macro PRM_RD_SKIPZERO_EN: zero words other than the |
// | last are captured but not emitted.                                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module prm_chk_reader
   import prm_chk_pkg::*;
#(
   parameter int SETTLE_CYC = 1
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              start,
   input  logic              abort,
   output logic [SEL1_W-1:0] sel1,
   output logic [SEL2_W-1:0] sel2,
   input  logic [WORD_W-1:0] result_imp,
   output logic [WORD_W-1:0] m_data,
   output logic [IDX_W-1:0]  m_idx,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

`ifdef PRM_RD_SKIPZERO_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   // Settle counter value on the final SEL cycle.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [3:0]       settle_cnt;
   logic [IDX_W-1:0] idx_nxt;
   sel_t             sel_nxt;

   assign idx_nxt = idx + 1'b1;
   assign sel_nxt = idx_to_sel(idx_nxt);

   // Scan sequencer: owns the index, the selects and every output register.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         sel1       <= '0;
         sel2       <= '0;
         m_data     <= '0;
         m_idx      <= '0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && abort) begin
            // Abort wins over a same-cycle handshake; the beat is dropped.
            state   <= IDLE;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     idx        <= '0;
                     settle_cnt <= '0;
                     sel1       <= idx_to_sel('0).sel1;
                     sel2       <= idx_to_sel('0).sel2;
                     busy       <= 1'b1;
                     state      <= SEL;
                  end
               end
               SEL: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= CAP;
                  end else begin
                     settle_cnt <= settle_cnt + 4'd1;
                  end
               end
               CAP: begin
                  if (SKIP_ZERO && result_imp == '0 && idx != LAST_IDX) begin
                     // Empty word: move straight on to the next index.
                     idx        <= idx_nxt;
                     settle_cnt <= '0;
                     sel1       <= sel_nxt.sel1;
                     sel2       <= sel_nxt.sel2;
                     state      <= SEL;
                  end else begin
                     m_data  <= result_imp;
                     m_idx   <= idx;
                     m_valid <= 1'b1;
                     m_last  <= (idx == LAST_IDX);
                     state   <= OUT;
                  end
               end
               OUT: begin
                  if (m_ready) begin
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        idx        <= idx_nxt;
                        settle_cnt <= '0;
                        sel1       <= sel_nxt.sel1;
                        sel2       <= sel_nxt.sel2;
                        state      <= SEL;
                     end
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
